// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_unit
//  Purpose  : Program-counter stage feeding the instruction memory of the
//             single-cycle CPU. Selects the next byte address from
//             sequential / branch / jump / jump-register targets, holds for
//             a start-up delay after reset, supports a terminal halt state
//             and counts retired PC updates.
//  Ports    : clk        - system clock, rising edge
//             reset      - synchronous active-high reset
//             pc_write   - PC update enable (0 = stall)
//             branch     - conditional branch instruction
//             zero       - ALU zero flag (branch taken when branch & zero)
//             jump       - J-type jump instruction
//             jr         - jump-register instruction
//             halt_ins   - halt opcode
//             im         - 16-bit immediate (word offset for branches)
//             ins_addr   - 26-bit jump target field (word address)
//             jr_addr    - register rs value for jr
//             pc         - current PC
//             pc_plus4   - pc + 4 (combinational)
//             halted     - registered halt indicator
//             ins_count  - number of PC updates performed in RUN
//  Revision : 1.0 - initial release
// ============================================================================
module pc_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          START_DELAY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_write,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic        jr,
  input  logic        halt_ins,
  input  logic [15:0] im,
  input  logic [25:0] ins_addr,
  input  logic [31:0] jr_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic [31:0] ins_count
);

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  localparam logic [3:0]  c_DELAY_LAST = 4'(START_DELAY - 1);
  localparam logic [31:0] c_PC_STEP    = 32'd4;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_delay;
  logic [31:0] r_pc;
  logic [31:0] r_ins_count;
  logic        r_halted;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_branch_off;
  logic [31:0] w_jr_target;
  logic [31:0] w_next_pc;
  logic        w_update;

  // --------------------------------------------------------------------------
  // Next-PC selection (all sums modulo 2^32)
  // --------------------------------------------------------------------------
  assign w_pc_plus4   = r_pc + c_PC_STEP;
  // Sign-extended word offset converted to a byte offset.
  assign w_branch_off = {{14{im[15]}}, im, 2'b00};
  // Misaligned register targets are forced onto a word boundary.
  assign w_jr_target  = jr_addr & 32'hFFFF_FFFC;

  always_comb begin
    w_next_pc = w_pc_plus4;
    if (jr) begin
      w_next_pc = w_jr_target;
    end else if (jump) begin
      w_next_pc = {w_pc_plus4[31:28], ins_addr, 2'b00};
    end else if (branch && zero) begin
      w_next_pc = w_pc_plus4 + w_branch_off;
    end
  end

  // A PC update only happens in RUN when not halting and not stalled.
  assign w_update = (r_state == S_RUN) && !halt_ins && pc_write;

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT: begin
        if (r_delay == c_DELAY_LAST) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (halt_ins) begin
          w_state_nxt = S_HALTED;
        end
      end
      S_HALTED: begin
        w_state_nxt = S_HALTED;
      end
      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_ins_count <= 32'd0;
      r_halted    <= 1'b0;
      r_delay     <= 4'd0;
    end else begin
      if (r_state == S_INIT) begin
        r_delay <= r_delay + 4'd1;
      end
      if (w_update) begin
        r_pc        <= w_next_pc;
        r_ins_count <= r_ins_count + 32'd1;
      end
      // Registered so that halted rises the cycle after the halt opcode.
      r_halted <= (w_state_nxt == S_HALTED);
    end
  end

  assign pc        = r_pc;
  assign pc_plus4  = w_pc_plus4;
  assign halted    = r_halted;
  assign ins_count = r_ins_count;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_unit
//  Purpose  : Directed-vector bench for pc_unit. Stimulus pushes the expected
//             post-edge state, tagged with the cycle it applies to, into a
//             queue; an independent monitor pops and compares on the falling
//             edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

  logic        clk;
  logic        reset;
  logic        pc_write;
  logic        branch;
  logic        zero;
  logic        jump;
  logic        jr;
  logic        halt_ins;
  logic [15:0] im;
  logic [25:0] ins_addr;
  logic [31:0] jr_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;
  logic [31:0] ins_count;

  pc_unit #(
    .RESET_PC    (32'h0000_0000),
    .START_DELAY (1)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .pc_write  (pc_write),
    .branch    (branch),
    .zero      (zero),
    .jump      (jump),
    .jr        (jr),
    .halt_ins  (halt_ins),
    .im        (im),
    .ins_addr  (ins_addr),
    .jr_addr   (jr_addr),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .halted    (halted),
    .ins_count (ins_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic        halted;
    logic [31:0] cnt;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc     = 0;
  int   n_check = 0;
  int   n_fail  = 0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Monitor: compares every expectation whose cycle has been reached.
  initial forever begin
    exp_t e;
    @(negedge clk);
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_check = n_check + 1;
      if (pc !== e.pc || halted !== e.halted || ins_count !== e.cnt ||
          pc_plus4 !== (e.pc + 32'd4)) begin
        n_fail = n_fail + 1;
        $display("FAIL %s: got pc=%h pc_plus4=%h halted=%b cnt=%0d, want pc=%h pc_plus4=%h halted=%b cnt=%0d",
                 e.name, pc, pc_plus4, halted, ins_count,
                 e.pc, e.pc + 32'd4, e.halted, e.cnt);
      end
    end
  end

  task automatic clr();
    reset    = 1'b0;
    pc_write = 1'b1;
    branch   = 1'b0;
    zero     = 1'b0;
    jump     = 1'b0;
    jr       = 1'b0;
    halt_ins = 1'b0;
    im       = 16'h0;
    ins_addr = 26'h0;
    jr_addr  = 32'h0;
  endtask

  // Push the state expected after the coming edge, then advance one cycle.
  task automatic step(input logic [31:0] epc, input logic eh,
                      input logic [31:0] ecnt, input string nm);
    exp_t e;
    e.cyc    = cyc + 1;
    e.pc     = epc;
    e.halted = eh;
    e.cnt    = ecnt;
    e.name   = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic load_pc(input logic [31:0] addr, input logic [31:0] ecnt);
    clr();
    jr      = 1'b1;
    jr_addr = addr;
    step(addr & 32'hFFFF_FFFC, 1'b0, ecnt, "jr_load");
  endtask

  initial begin
    clr();
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    clr(); reset = 1'b1;
    step(32'h0, 1'b0, 32'd0, "reset");

    // INIT cycle holds pc, then sequential fetch
    clr();
    step(32'h0, 1'b0, 32'd0, "init_hold");
    step(32'h4, 1'b0, 32'd1, "seq1");
    step(32'h8, 1'b0, 32'd2, "seq2");
    step(32'hC, 1'b0, 32'd3, "seq3");

    // Branch taken backwards (misaligned jr load also checked)
    load_pc(32'h0000_0013, 32'd4);
    clr(); branch = 1'b1; zero = 1'b1; im = 16'hFFFE;
    step(32'h0C, 1'b0, 32'd5, "branch_taken");

    // Branch not taken
    load_pc(32'h0000_0010, 32'd6);
    clr(); branch = 1'b1; zero = 1'b0; im = 16'hFFFE;
    step(32'h14, 1'b0, 32'd7, "branch_not_taken");

    // Jump keeps upper nibble of pc+4
    load_pc(32'h7000_0000, 32'd8);
    clr(); jump = 1'b1; ins_addr = 26'h000_0040;
    step(32'h7000_0100, 1'b0, 32'd9, "jump");

    // jr wins over jump and branch
    clr(); jr = 1'b1; jr_addr = 32'h0000_0123; jump = 1'b1;
    ins_addr = 26'h3FF_FFFF; branch = 1'b1; zero = 1'b1; im = 16'h0010;
    step(32'h120, 1'b0, 32'd10, "prio_jr");

    // jump wins over branch
    clr(); jump = 1'b1; ins_addr = 26'h000_0008; branch = 1'b1; zero = 1'b1;
    im = 16'h0100;
    step(32'h20, 1'b0, 32'd11, "prio_jump");

    // Sequential wrap at top of address space
    load_pc(32'hFFFF_FFFC, 32'd12);
    clr();
    step(32'h0, 1'b0, 32'd13, "wrap_seq");

    // Negative branch offset wraps below zero: 4 - 8
    clr(); branch = 1'b1; zero = 1'b1; im = 16'hFFFE;
    step(32'hFFFF_FFFC, 1'b0, 32'd14, "wrap_branch");

    // Stall with control inputs active
    load_pc(32'h0000_0020, 32'd15);
    for (int i = 0; i < 3; i++) begin
      clr(); pc_write = 1'b0; jump = 1'b1; ins_addr = 26'h000_1000;
      step(32'h20, 1'b0, 32'd15, "stall");
    end

    // Halt takes priority over jump and pc_write
    clr(); halt_ins = 1'b1; jump = 1'b1; ins_addr = 26'h000_1000;
    step(32'h20, 1'b1, 32'd15, "halt_enter");
    for (int i = 0; i < 2; i++) begin
      clr(); jump = 1'b1; jr = 1'b1; jr_addr = 32'h0000_4000;
      ins_addr = 26'h000_1000;
      step(32'h20, 1'b1, 32'd15, "halt_frozen");
    end

    // Reset out of HALTED, then restart
    clr(); reset = 1'b1; jump = 1'b1;
    step(32'h0, 1'b0, 32'd0, "reset_from_halt");
    clr(); jump = 1'b1; ins_addr = 26'h000_1000;
    step(32'h0, 1'b0, 32'd0, "init_ignores_inputs");
    clr();
    step(32'h4, 1'b0, 32'd1, "restart_seq");

    // Reset in the middle of a stall
    clr(); pc_write = 1'b0;
    step(32'h4, 1'b0, 32'd1, "stall2");
    clr(); reset = 1'b1; pc_write = 1'b0;
    step(32'h0, 1'b0, 32'd0, "reset_mid_stall");

    // Drain the scoreboard with a bounded wait
    begin
      int budget;
      budget = 20;
      while (q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget = budget - 1;
      end
      @(negedge clk);
      #1;
      if (q.size() > 0) begin
        n_check = n_check + 1;
        n_fail  = n_fail + 1;
        $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
      end
    end

    $display("%0d/%0d checks passed", n_check - n_fail, n_check);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
